regfile_writeback_sequencer: RTL and testbench
==============================================

// Module: regfile_writeback_sequencer
// PURPOSE
//  Write-side master for the 16x16 multi-port register file: collects write-back requests from
//  two producers (ALU, memory/load unit), arbitrates round-robin, buffers them in a small FIFO
//  and drives the file's single write port (write_enable/write_address/data_in), one per cycle.
//  Exports a pending-write mask so issue logic can hold reads of not-yet-written registers.
// PARAMETERS
//  DATA_W   16  register width; must match the register file
//  ADDR_W   4   register index width (16 registers)
//  DEPTH    4   FIFO entries, power of two, >=2
// PORTS
//  clk             in   1       clock, all state on rising edge
//  reset_n         in   1       asynchronous, active-low reset
//  alu_valid       in   1       ALU write-back request
//  alu_ready       out  1       ALU request accepted this cycle when valid&ready
//  alu_addr        in   ADDR_W  ALU destination register
//  alu_data        in   DATA_W  ALU result
//  mem_valid       in   1       load-unit write-back request
//  mem_ready       out  1       load request accepted when valid&ready
//  mem_addr        in   ADDR_W  load destination register
//  mem_data        in   DATA_W  load data
//  rf_hold         in   1       stall: do not issue a file write this cycle
//  rf_write_enable out  1       to register file write_enable (registered)
//  rf_write_addr   out  ADDR_W  to register file write_address (registered)
//  rf_data_in      out  DATA_W  to register file data_in (registered)
//  pending_mask    out  16      bit r set: a write to register r is queued or being issued
//  fifo_count      out  $clog2(DEPTH)+1  occupied entries
//  lookup_addr     in   ADDR_W  forwarding lookup address (WB_FORWARD_EN)
//  fwd_hit         out  1       forwarding hit (WB_FORWARD_EN)
//  fwd_data        out  DATA_W  forwarded value (WB_FORWARD_EN)
// BEHAVIOUR
//  - Reset (reset_n low, any time, immediate): FIFO emptied, pointers/count 0, rr pointer -> ALU
//    first, rf_write_enable/addr/data 0, pending_mask 0, fwd_hit 0. In-flight requests dropped.
//  - Accept: full = (fifo_count==DEPTH). At most one enqueue per cycle. Both valid: grant the
//    source not granted last (reset: ALU). One valid: grant it. ready = !full & granted;
//    ready may depend combinationally on the other source's valid; valid must not depend on ready.
//  - rr pointer toggles only when both valid and an enqueue occurs.
//  - Issue: at each edge, if FIFO non-empty and !rf_hold: pop head into output regs,
//    rf_write_enable=1 next cycle; else rf_write_enable=0 (addr/data hold last value).
//  - Latency: request accepted at edge E0 into an empty FIFO -> rf_write_enable high E1..E2,
//    file captures at E2. Back-to-back: one write per cycle sustained.
//  - Simultaneous enqueue+pop: both happen, count unchanged. Full does not credit a same-cycle pop
//    (ready independent of rf_hold).
//  - Order: file writes occur in acceptance order; same-address entries retire oldest first.
//  - pending_mask = OR of decoded addr of every valid FIFO entry, plus rf_write_addr when
//    rf_write_enable=1. Combinational from state only.
//  - Pointers wrap modulo DEPTH; count is DEPTH+1 valued (0..DEPTH), never wraps.
// CONFIGURATION
//  WB_FORWARD_EN defined: fwd_hit=1 when lookup_addr matches any valid FIFO entry or the active
//    output reg; fwd_data = data of the youngest match (output reg oldest). Combinational.
//  WB_FORWARD_EN undefined: no compare logic; fwd_hit=0, fwd_data=0; lookup_addr ignored.
// STRUCTURE
//  Package regfile_wb_pkg: DATA_W/ADDR_W/NUM_REGS constants, wb_entry_t {addr,data} struct,
//    wb_src_e {WB_SRC_ALU, WB_SRC_MEM}.
//  Sub-module wb_rr_arbiter (2-way round-robin grant + pointer); FIFO and forwarding inline.
// TESTING
//  1 Reset, single ALU req addr 3 data 16'hA5A5 -> rf_write_enable high exactly one cycle after
//    accept with addr 3/data A5A5; pending_mask bit3 set until that write cycle ends.
//  2 ALU and MEM valid every cycle, rf_hold=0 -> grants alternate ALU,MEM,ALU...; writes in order.
//  3 rf_hold=1, push 4 reqs -> fifo_count=4, both ready=0; release -> 4 writes consecutive cycles.
//  4 Full FIFO, rf_hold=0, new valid -> ready stays 0 that cycle; accepted next cycle, count steady.
//  5 Two queued writes to reg 7 (11,22), WB_FORWARD_EN, lookup 7 -> fwd_hit=1, fwd_data=22; reg 7
//    written 11 then 22; without macro fwd_hit=0.
//  6 reset_n low mid-burst with 3 entries -> outputs 0 immediately, no further writes after release.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared constants and types for the register-file write-back sequencer.
package regfile_wb_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter between the ALU and load-unit write-back sources.
module wb_rr_arbiter (
  input  logic clk,
  input  logic reset_n,
  input  logic alu_valid,
  input  logic mem_valid,
  input  logic full,
  output logic alu_grant_c,
  output logic mem_grant_c
);
  import regfile_wb_pkg::*;

  wb_src_e prio_q, prio_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prio_q <= WB_SRC_ALU;
    else          prio_q <= prio_d;
  end

  // Priority flips only when a contested grant is actually enqueued.
  always_comb begin
    prio_d      = prio_q;
    alu_grant_c = 1'b0;
    mem_grant_c = 1'b0;
    if (alu_valid && mem_valid) begin
      alu_grant_c = (prio_q == WB_SRC_ALU);
      mem_grant_c = (prio_q == WB_SRC_MEM);
      if (!full) prio_d = (prio_q == WB_SRC_ALU) ? WB_SRC_MEM : WB_SRC_ALU;
    end else begin
      alu_grant_c = alu_valid;
      mem_grant_c = mem_valid;
    end
  end

endmodule

// File: rtl/regfile_writeback_sequencer.sv
// Write-port master for the 16x16 register file: arbitrates ALU/load write-backs into a FIFO
// and issues one file write per cycle. Optional forwarding lookup under WB_FORWARD_EN.
module regfile_writeback_sequencer #(
  parameter int unsigned DATA_W = regfile_wb_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_wb_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                alu_valid,
  output logic                                alu_ready,
  input  logic [ADDR_W-1:0]                   alu_addr,
  input  logic [DATA_W-1:0]                   alu_data,
  input  logic                                mem_valid,
  output logic                                mem_ready,
  input  logic [ADDR_W-1:0]                   mem_addr,
  input  logic [DATA_W-1:0]                   mem_data,
  input  logic                                rf_hold,
  output logic                                rf_write_enable,
  output logic [ADDR_W-1:0]                   rf_write_addr,
  output logic [DATA_W-1:0]                   rf_data_in,
  output logic [regfile_wb_pkg::NUM_REGS-1:0] pending_mask,
  output logic [$clog2(DEPTH):0]              fifo_count,
  input  logic [ADDR_W-1:0]                   lookup_addr,
  output logic                                fwd_hit,
  output logic [DATA_W-1:0]                   fwd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full_c, empty_c, push_c, pop_c;
  logic             alu_grant_c, mem_grant_c;
  entry_t           push_entry_c;

  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign empty_c    = (count_q == '0);
  assign pop_c      = !empty_c && !rf_hold;
  assign fifo_count = count_q;

  wb_rr_arbiter u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .alu_valid   (alu_valid),
    .mem_valid   (mem_valid),
    .full        (full_c),
    .alu_grant_c (alu_grant_c),
    .mem_grant_c (mem_grant_c)
  );

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign alu_ready = alu_grant_c && !full_c;
  assign mem_ready = mem_grant_c && !full_c;
  assign push_c    = alu_ready || mem_ready;

  always_comb begin
    push_entry_c.addr = mem_addr;
    push_entry_c.data = mem_data;
    if (alu_grant_c) begin
      push_entry_c.addr = alu_addr;
      push_entry_c.data = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= push_entry_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      count_q <= count_q + CNT_W'(1);
      else if (pop_c && !push_c) count_q <= count_q - CNT_W'(1);
    end
  end

  // File write port; address/data hold their last value while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_data_in      <= '0;
    end else begin
      rf_write_enable <= pop_c;
      if (pop_c) begin
        rf_write_addr <= fifo_q[rd_ptr_q].addr;
        rf_data_in    <= fifo_q[rd_ptr_q].data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (rf_write_enable) pending_mask[rf_write_addr] = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_q) pending_mask[fifo_q[rd_ptr_q + PTR_W'(k)].addr] = 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (rf_write_enable && (rf_write_addr == lookup_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = rf_data_in;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) && (fifo_q[rd_ptr_q + PTR_W'(k)].addr == lookup_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_q[rd_ptr_q + PTR_W'(k)].data;
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^lookup_addr;
  assign fwd_hit       = 1'b0;
  assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_sequencer.sv
// Randomized self-checking bench for regfile_writeback_sequencer against a queue-based model.
module tb_regfile_writeback_sequencer;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, mem_valid, rf_hold;
  logic        alu_ready, mem_ready;
  logic [3:0]  alu_addr, mem_addr, lookup_addr;
  logic [15:0] alu_data, mem_data;
  logic        rf_write_enable;
  logic [3:0]  rf_write_addr;
  logic [15:0] rf_data_in;
  logic [15:0] pending_mask;
  logic [2:0]  fifo_count;
  logic        fwd_hit;
  logic [15:0] fwd_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: accepted requests in order, the write port, and who wins the next contest.
  ent_t        mq[$];
  logic        m_en;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  logic        m_prio_alu;

  regfile_writeback_sequencer #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .rf_hold         (rf_hold),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_data_in      (rf_data_in),
    .pending_mask    (pending_mask),
    .fifo_count      (fifo_count),
    .lookup_addr     (lookup_addr),
    .fwd_hit         (fwd_hit),
    .fwd_data        (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_en       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    m_prio_alu = 1'b1;
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [15:0] md,
                       input logic hold, input logic [3:0] look);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    rf_hold = hold; lookup_addr = look;
  endtask

  task automatic drive_idle(input logic hold);
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, hold, 4'd0);
  endtask

  task automatic drive_random(input int hold_pct);
    drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
          1'($urandom_range(0, 99) < hold_pct), 4'($urandom_range(0, 15)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"},    32'(rf_write_enable), 32'd0);
    check_eq({tag, "_waddr"}, 32'(rf_write_addr), 32'd0);
    check_eq({tag, "_wdata"}, 32'(rf_data_in), 32'd0);
    check_eq({tag, "_count"}, 32'(fifo_count), 32'd0);
    check_eq({tag, "_pend"},  32'(pending_mask), 32'd0);
    check_eq({tag, "_fhit"},  32'(fwd_hit), 32'd0);
  endtask

  // Compare at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    logic        full, both, ea, em;
    logic [15:0] pm, fd;
    logic        fh;
    ent_t        e;
    @(negedge clk);
    full = (mq.size() == DEPTH);
    both = alu_valid && mem_valid;
    ea   = alu_valid && !full && (!mem_valid || m_prio_alu);
    em   = mem_valid && !full && (!alu_valid || !m_prio_alu);
    pm   = '0;
    if (m_en) pm[m_addr] = 1'b1;
    foreach (mq[i]) pm[mq[i].addr] = 1'b1;
    fh = 1'b0;
    fd = '0;
`ifdef WB_FORWARD_EN
    if (m_en && m_addr == lookup_addr) begin fh = 1'b1; fd = m_data; end
    foreach (mq[i]) if (mq[i].addr == lookup_addr) begin fh = 1'b1; fd = mq[i].data; end
`endif
    check_eq("alu_ready", 32'(alu_ready), 32'(ea));
    check_eq("mem_ready", 32'(mem_ready), 32'(em));
    check_eq("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check_eq("rf_we", 32'(rf_write_enable), 32'(m_en));
    check_eq("rf_addr", 32'(rf_write_addr), 32'(m_addr));
    check_eq("rf_data", 32'(rf_data_in), 32'(m_data));
    check_eq("pending", 32'(pending_mask), 32'(pm));
    check_eq("fwd_hit", 32'(fwd_hit), 32'(fh));
    check_eq("fwd_data", 32'(fwd_data), 32'(fd));
    @(posedge clk);
    if (mq.size() > 0 && !rf_hold) begin
      e = mq.pop_front();
      m_en = 1'b1; m_addr = e.addr; m_data = e.data;
    end else begin
      m_en = 1'b0;
    end
    if (ea)      mq.push_back('{alu_addr, alu_data});
    else if (em) mq.push_back('{mem_addr, mem_data});
    if (both && (ea || em)) m_prio_alu = !m_prio_alu;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive_idle(1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Single ALU write: visible on the port one cycle after acceptance.
    drive(1'b1, 4'd3, 16'hA5A5, 1'b0, 4'd0, 16'd0, 1'b0, 4'd3);
    cycle();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd3);
    repeat (3) cycle();

    // Both sources every cycle: grants alternate.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 16'($urandom),
            1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 1'b0, 4'($urandom_range(0, 15)));
      cycle();
    end

    // Fill under hold, then release while still offering requests.
    drive_idle(1'b0);
    repeat (4) cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'(i), 16'(16'h100 + i), 1'b1, 4'(i + 8), 16'(16'h200 + i), 1'b1, 4'(i));
      cycle();
    end
    drive(1'b1, 4'd9, 16'h0909, 1'b0, 4'd0, 16'd0, 1'b0, 4'd9);
    repeat (3) cycle();
    drive_idle(1'b0);
    repeat (6) cycle();

    // Two queued writes to reg 7, then forwarding lookup and drain.
    drive(1'b1, 4'd7, 16'h0011, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7);
    cycle();
    drive(1'b1, 4'd7, 16'h0022, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7);
    cycle();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd7);
    cycle();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd7);
    repeat (4) cycle();

    for (int i = 0; i < 400; i++) begin
      drive_random((i % 100 < 30) ? 70 : 15);
      cycle();
    end

    // Asynchronous reset with entries queued.
    drive_idle(1'b0);
    repeat (6) cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 4), 16'(16'hBEE0 + i), 1'b0, 4'd0, 16'd0, 1'b1, 4'd0);
      cycle();
    end
    drive_idle(1'b0);
    cycle();
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) cycle();

    for (int i = 0; i < 100; i++) begin
      drive_random(25);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
